// File: rtl/floor_request_module_if.sv
// Bus bundle for floor_request_module: raw buttons, serve/ack inputs,
// and the registered request outputs offered to the elevator controller.
interface floor_request_module_if #(
    parameter int NUM_FLOORS = 4
);
    logic [NUM_FLOORS-1:0] bt_floor;
    logic                  req_ack;
    logic [NUM_FLOORS-1:0] floor_served;
    logic [NUM_FLOORS-1:0] memory_address_buffer;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] ctrl_load;
    logic                  req_valid;

    modport master (
        output bt_floor, req_ack, floor_served,
        input  memory_address_buffer, pending, ctrl_load, req_valid
    );

    modport slave (
        input  bt_floor, req_ack, floor_served,
        output memory_address_buffer, pending, ctrl_load, req_valid
    );
endinterface

// File: rtl/floor_request_module.sv
// Floor button synchronizer/debouncer, pending-request mask and one-hot request arbiter.
// Define FLOOR_RR_ARB_EN for round-robin selection; default is fixed lowest-index priority.
module floor_request_module #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    floor_request_module_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(NUM_FLOORS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    logic [NUM_FLOORS-1:0] sync_p0, sync_p1;
    logic [NUM_FLOORS-1:0] level_p2, level_p3;
    logic [CW-1:0]         cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] pending_q, mab_q;
    logic [NUM_FLOORS-1:0] load_q, load_n;
    logic [NUM_FLOORS-1:0] avail;
    logic                  valid_q, valid_n;
    logic                  hit;
    logic [PW-1:0]         sel;
    state_t                state, state_n;

    function automatic logic is_one_hot(input logic [NUM_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - NUM_FLOORS'(1))) == '0);
    endfunction

`ifdef FLOOR_RR_ARB_EN
    logic [PW-1:0] ptr, ptr_n;

    // Rank each set bit by its upward distance from the slot after the last grant.
    function automatic logic [PW-1:0] pick(input logic [NUM_FLOORS-1:0] v,
                                           input logic [PW-1:0] last);
        int best;
        int dist;
        logic [PW-1:0] idx;
        best = NUM_FLOORS;
        idx  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            dist = (i - int'(last) - 1 + 2 * NUM_FLOORS) % NUM_FLOORS;
            if (v[i] && dist < best) begin
                best = dist;
                idx  = PW'(i);
            end
        end
        return idx;
    endfunction

    assign sel = pick(avail, ptr);
`else
    function automatic logic [PW-1:0] pick(input logic [NUM_FLOORS-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    assign sel = pick(avail);
`endif

    // Stages p0/p1: metastability synchronizer; p2: debounced level; p3: delayed level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            level_p2 <= '0;
            level_p3 <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
        end else begin
            sync_p0  <= bus.bt_floor;
            sync_p1  <= sync_p0;
            level_p3 <= level_p2;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync_p1[i] == level_p2[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]      <= '0;
                    level_p2[i] <= ~level_p2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = level_p2 & ~level_p3;

    // Serve wins over a same-cycle press on the same floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mab_q     <= '0;
        end else begin
            pending_q <= (pending_q | rise) & ~bus.floor_served;
            mab_q     <= is_one_hot(level_p2) ? level_p2 : '0;
        end
    end

    assign avail = pending_q & ~bus.floor_served;
    assign hit   = |(bus.floor_served & load_q);

    always_comb begin
        state_n = state;
        load_n  = load_q;
        valid_n = valid_q;
`ifdef FLOOR_RR_ARB_EN
        ptr_n   = ptr;
`endif
        case (state)
            IDLE: begin
                load_n  = '0;
                valid_n = 1'b0;
                if (avail != '0) begin
                    load_n[sel] = 1'b1;
                    valid_n     = 1'b1;
                    state_n     = OFFER;
`ifdef FLOOR_RR_ARB_EN
                    ptr_n       = sel;
`endif
                end
            end
            OFFER: begin
                // A serve on the offered floor withdraws the offer even if acked now.
                if (hit) begin
                    load_n  = '0;
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (bus.req_ack) begin
                    valid_n = 1'b0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (hit) begin
                    load_n  = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                load_n  = '0;
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            load_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            load_q  <= load_n;
            valid_q <= valid_n;
        end
    end

`ifdef FLOOR_RR_ARB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_n;
    end
`endif

    assign bus.memory_address_buffer = mab_q;
    assign bus.pending               = pending_q;
    assign bus.ctrl_load             = load_q;
    assign bus.req_valid             = valid_q;
endmodule

// File: tb/tb_floor_request_module.sv
// Self-checking bench for floor_request_module: directed scenarios with literal
// expectations plus randomized traffic against a window-based behavioural model.
module tb_floor_request_module;
    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    floor_request_module_if #(.NUM_FLOORS(N)) bus ();

    floor_request_module #(.NUM_FLOORS(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: 2-sample input delay, level flips when the last D synced
    // samples all disagree with it, arbiter tracked as target + offered flag.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_lvl_d, m_pend, m_mab, m_tgt;
    logic         m_vld;
    int           m_last;
    logic [N-1:0] m_win [D];

    task automatic mdl_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_lvl_d = '0;
        m_pend = '0; m_mab = '0; m_tgt = '0; m_vld = 1'b0; m_last = 0;
        for (int j = 0; j < D; j++) m_win[j] = '0;
    endtask

    function automatic int choose(input logic [N-1:0] v, input int last);
`ifdef FLOOR_RR_ARB_EN
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return last;
    endfunction

    task automatic mdl_step(input logic [N-1:0] b, input logic a, input logic [N-1:0] s);
        logic [N-1:0] rise, avail, nlvl;
        logic all_diff;
        rise  = m_lvl & ~m_lvl_d;
        avail = m_pend & ~s;
        if (m_tgt == '0) begin
            if (avail != '0) begin
                m_last = choose(avail, m_last);
                m_tgt  = N'(1) << m_last;
                m_vld  = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end else if ((s & m_tgt) != '0) begin
            m_tgt = '0;
            m_vld = 1'b0;
        end else if (m_vld && a) begin
            m_vld = 1'b0;
        end
        m_pend  = (m_pend | rise) & ~s;
        m_mab   = ($countones(m_lvl) == 1) ? m_lvl : '0;
        m_lvl_d = m_lvl;
        for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = m_d2;
        nlvl = m_lvl;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (m_win[j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) nlvl[i] = ~m_lvl[i];
        end
        m_lvl = nlvl;
        m_d2  = m_d1;
        m_d1  = b;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mdl_pending", 32'(bus.pending), 32'(m_pend));
        chk("mdl_mab", 32'(bus.memory_address_buffer), 32'(m_mab));
        chk("mdl_ctrl_load", 32'(bus.ctrl_load), 32'(m_tgt));
        chk("mdl_req_valid", 32'(bus.req_valid), 32'(m_vld));
        chk("ctrl_load_onehot0", 32'($countones(bus.ctrl_load) <= 1), 32'd1);
    endtask

    // One clock: drive at negedge, step model with the same inputs, compare after the edge.
    task automatic cyc(input logic [N-1:0] b, input logic a, input logic [N-1:0] s);
        @(negedge clk);
        bus.bt_floor     = b;
        bus.req_ack      = a;
        bus.floor_served = s;
        @(posedge clk);
        if (!rst_n) mdl_reset();
        else        mdl_step(b, a, s);
        #1;
        compare_all();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, '0);
    endtask

    logic [N-1:0] first_t, second_t;
    logic [N-1:0] bt_r, srv_r;
    logic         ack_r;

    initial begin
        bus.bt_floor = '0; bus.req_ack = 1'b0; bus.floor_served = '0;
        mdl_reset();
`ifdef FLOOR_RR_ARB_EN
        first_t = 4'b1000; second_t = 4'b0001;
`else
        first_t = 4'b0001; second_t = 4'b1000;
`endif
        idle(3);
        chk("reset_pending", 32'(bus.pending), 32'h0);
        chk("reset_ctrl_load", 32'(bus.ctrl_load), 32'h0);
        chk("reset_req_valid", 32'(bus.req_valid), 32'h0);
        chk("reset_mab", 32'(bus.memory_address_buffer), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Single press: pending at edge 7, offered at edge 8.
        for (int i = 1; i <= 6; i++) cyc(4'b0010, 1'b0, '0);
        chk("a_pending_e6", 32'(bus.pending), 32'h0);
        cyc(4'b0010, 1'b0, '0);
        chk("a_pending_e7", 32'(bus.pending), 32'h2);
        chk("a_mab_e7", 32'(bus.memory_address_buffer), 32'h2);
        cyc(4'b0010, 1'b0, '0);
        chk("a_ctrl_load_e8", 32'(bus.ctrl_load), 32'h2);
        chk("a_req_valid_e8", 32'(bus.req_valid), 32'h1);
        cyc(4'b0010, 1'b1, '0);
        chk("a_busy_valid", 32'(bus.req_valid), 32'h0);
        chk("a_busy_load", 32'(bus.ctrl_load), 32'h2);
        cyc(4'b0010, 1'b0, 4'b0010);
        chk("a_served_load", 32'(bus.ctrl_load), 32'h0);
        chk("a_served_pending", 32'(bus.pending), 32'h0);
        idle(10);

        // Short glitch is rejected.
        for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            cyc('0, 1'b0, '0);
            chk("b_pending", 32'(bus.pending), 32'h0);
            chk("b_mab", 32'(bus.memory_address_buffer), 32'h0);
        end

        // Two simultaneous presses.
        for (int i = 1; i <= 7; i++) cyc(4'b1001, 1'b0, '0);
        chk("c_pending", 32'(bus.pending), 32'h9);
        chk("c_mab", 32'(bus.memory_address_buffer), 32'h0);
        cyc(4'b1001, 1'b0, '0);
        chk("c_first_load", 32'(bus.ctrl_load), 32'(first_t));
        chk("c_first_valid", 32'(bus.req_valid), 32'h1);
        cyc('0, 1'b1, '0);
        cyc('0, 1'b0, first_t);
        chk("c_pending_after", 32'(bus.pending), 32'(4'b1001 & ~first_t));
        chk("c_idle_load", 32'(bus.ctrl_load), 32'h0);
        cyc('0, 1'b0, '0);
        chk("c_second_load", 32'(bus.ctrl_load), 32'(second_t));
        chk("c_second_valid", 32'(bus.req_valid), 32'h1);
        cyc('0, 1'b1, '0);
        cyc('0, 1'b0, second_t);
        idle(10);

        // Long unacknowledged offer, then withdrawn by serve with a same-cycle ack.
        for (int i = 1; i <= 8; i++) cyc(4'b0100, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            cyc('0, 1'b0, '0);
            chk("d_hold_load", 32'(bus.ctrl_load), 32'h4);
            chk("d_hold_valid", 32'(bus.req_valid), 32'h1);
        end
        cyc('0, 1'b1, 4'b0100);
        chk("d_withdraw_valid", 32'(bus.req_valid), 32'h0);
        chk("d_withdraw_load", 32'(bus.ctrl_load), 32'h0);
        chk("d_withdraw_pending", 32'(bus.pending[2]), 32'h0);
        idle(10);

        // Asynchronous reset in BUSY with the button still held, then re-acceptance.
        for (int i = 1; i <= 8; i++) cyc(4'b1000, 1'b0, '0);
        cyc(4'b1000, 1'b1, '0);
        chk("e_busy_load", 32'(bus.ctrl_load), 32'h8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("e_async_pending", 32'(bus.pending), 32'h0);
        chk("e_async_load", 32'(bus.ctrl_load), 32'h0);
        chk("e_async_valid", 32'(bus.req_valid), 32'h0);
        chk("e_async_mab", 32'(bus.memory_address_buffer), 32'h0);
        mdl_reset();
        cyc(4'b1000, 1'b0, '0);
        cyc(4'b1000, 1'b0, '0);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) cyc(4'b1000, 1'b0, '0);
        chk("e_rearm_e6", 32'(bus.pending), 32'h0);
        cyc(4'b1000, 1'b0, '0);
        chk("e_rearm_e7", 32'(bus.pending), 32'h8);
        idle(12);

        // Randomized traffic against the model.
        bt_r = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) bt_r[$urandom_range(0, N-1)] ^= 1'b1;
            ack_r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       srv_r = m_tgt;
                1:       srv_r = N'($urandom_range(0, 15));
                default: srv_r = '0;
            endcase
            cyc(bt_r, ack_r, srv_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
